// File: rtl/version_stream_tx.sv
// Build-identification record serialiser: frames the version_pkg constants with magic,
// sequence number and checksum, and streams the 16-byte record over valid/ready.

package version_pkg;
    localparam logic [7:0]  MAJOR  = 8'd2;
    localparam logic [7:0]  MINOR  = 8'd7;
    localparam logic [7:0]  PATCH  = 8'd3;
    localparam logic [7:0]  BUILD  = 8'd41;
    localparam logic [15:0] YEAR   = 16'd2024;
    localparam logic [7:0]  MONTH  = 8'd6;
    localparam logic [7:0]  DAY    = 8'd17;
    localparam logic [7:0]  HOUR   = 8'd13;
    localparam logic [7:0]  MINUTE = 8'd45;
    localparam logic [7:0]  SECOND = 8'd9;
endpackage

// state | meaning
// IDLE  | no record in flight, waiting for req or timer tick
// SEND  | presenting beats of the current record; a trigger here is held as pending
module version_stream_tx
    import version_pkg::*;
#(
    parameter int          DATA_W        = 8,
    parameter logic [15:0] MAGIC         = 16'h5652,
    parameter logic [7:0]  USER_ID       = 8'h00,
    parameter int          PERIOD_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic [7:0]        seq
);
    localparam int BPB    = DATA_W / 8;
    localparam int NBEATS = 16 / BPB;
    localparam int BW     = $clog2(NBEATS);
    localparam int TW     = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_width
        $error("version_stream_tx: DATA_W must be 8, 16 or 32");
    end
    if (PERIOD_CYCLES != 0 && PERIOD_CYCLES < 32) begin : g_bad_period
        $error("version_stream_tx: PERIOD_CYCLES must be 0 or >= 32");
    end

    // B0 sits in the least significant byte
    localparam logic [111:0] CONST_BYTES = {USER_ID, SECOND, MINUTE, HOUR, DAY, MONTH,
                                            YEAR[7:0], YEAR[15:8], BUILD, PATCH, MINOR, MAJOR,
                                            MAGIC[15:8], MAGIC[7:0]};

    function automatic logic [7:0] byte_sum(input logic [111:0] v);
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < 14; k++) s = s + v[k*8 +: 8];
        return s;
    endfunction

    localparam logic [7:0] CONST_SUM = byte_sum(CONST_BYTES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [7:0]      seq_q, seq_d;
    logic [7:0]      nxt_q, nxt_d;
    logic            pending_q, pending_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            timer_tick, trig, hs, last_beat;
    logic [7:0]      csum;
    logic [127:0]    rec;
    logic [NBEATS-1:0][DATA_W-1:0] rec_beats;

    assign timer_tick = (PERIOD_CYCLES != 0) && (timer_q == TW'(PERIOD_CYCLES - 1));
    assign trig       = req | timer_tick;
    assign hs         = m_valid & m_ready;
    assign last_beat  = (beat_q == BW'(NBEATS - 1));

    assign csum      = 8'd0 - CONST_SUM - seq_q;
    assign rec       = {csum, seq_q, CONST_BYTES};
    assign rec_beats = rec;

    assign m_valid = (state_q == SEND);
    assign m_data  = m_valid ? rec_beats[beat_q] : '0;
    assign m_last  = m_valid & last_beat;
    assign busy    = m_valid | pending_q;
    assign seq     = seq_q;

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (PERIOD_CYCLES == 0 || timer_tick) timer_d = '0;
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        seq_d     = seq_q;
        nxt_d     = nxt_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = SEND;
                    beat_d  = '0;
                    seq_d   = nxt_q;
                    nxt_d   = nxt_q + 8'd1;
                end
            end
            SEND: begin
                if (hs && last_beat) begin
                    beat_d = '0;
                    // back-to-back record; a trigger on this very edge re-arms pending
                    if (pending_q || trig) begin
                        seq_d     = nxt_q;
                        nxt_d     = nxt_q + 8'd1;
                        pending_d = pending_q & trig;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs)   beat_d    = beat_q + BW'(1);
                    if (trig) pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            seq_q     <= 8'd0;
            nxt_q     <= 8'd0;
            pending_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            seq_q     <= seq_d;
            nxt_q     <= nxt_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end
endmodule

// File: tb/tb_version_stream_tx.sv
// Scoreboard bench for version_stream_tx: three instances (8-bit, 16-bit, 32-bit with a
// 64-cycle timer) checked against a record-level model of triggers, pending and beats.
module tb_version_stream_tx;
    import version_pkg::*;

    logic clk;
    logic rst [3];
    logic req [3];
    logic rdy [3];
    logic vld [3];
    logic lst [3];
    logic bsy [3];
    logic [7:0]  seqo [3];
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [31:0] d32;
    logic [31:0] dd [3];

    assign dd[0] = {24'd0, d8};
    assign dd[1] = {16'd0, d16};
    assign dd[2] = d32;

    version_stream_tx #(.DATA_W(8), .PERIOD_CYCLES(0)) u_w8 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .m_data(d8), .m_valid(vld[0]),
        .m_ready(rdy[0]), .m_last(lst[0]), .busy(bsy[0]), .seq(seqo[0]));
    version_stream_tx #(.DATA_W(16), .PERIOD_CYCLES(0)) u_w16 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .m_data(d16), .m_valid(vld[1]),
        .m_ready(rdy[1]), .m_last(lst[1]), .busy(bsy[1]), .seq(seqo[1]));
    version_stream_tx #(.DATA_W(32), .PERIOD_CYCLES(64)) u_w32 (
        .clk(clk), .rst(rst[2]), .req(req[2]), .m_data(d32), .m_valid(vld[2]),
        .m_ready(rdy[2]), .m_last(lst[2]), .busy(bsy[2]), .seq(seqo[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: records outstanding (0 idle, 1 sending, 2 sending + one pending)
    int          mout [3];
    int          mbeat [3];
    int          mstarted [3];
    int          mn [3];
    logic [7:0]  mseq [3];
    logic [32:0] exp_q [3][$];
    int          rdy_mode [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, i, got, exp, $time);
        end
    endtask

    function automatic void start_rec(input int i);
        logic [7:0]  b [16];
        logic [31:0] w;
        int sum;
        int bpb;
        int nb;
        bpb = 1 << i;
        nb  = 16 >> i;
        b[0] = 8'h52;  b[1] = 8'h56;
        b[2] = MAJOR;  b[3] = MINOR;  b[4] = PATCH;  b[5] = BUILD;
        b[6] = YEAR[15:8];  b[7] = YEAR[7:0];
        b[8] = MONTH;  b[9] = DAY;  b[10] = HOUR;  b[11] = MINUTE;  b[12] = SECOND;
        b[13] = 8'h00;
        b[14] = 8'(mstarted[i]);
        sum = 0;
        for (int k = 0; k < 15; k++) sum += int'(b[k]);
        b[15] = 8'(256 - (sum % 256));
        for (int k = 0; k < nb; k++) begin
            w = '0;
            for (int j = 0; j < bpb; j++) w[j*8 +: 8] = b[k*bpb + j];
            exp_q[i].push_back({(k == nb - 1), w});
        end
        mseq[i] = 8'(mstarted[i]);
        mstarted[i]++;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            mout[i] = 0; mbeat[i] = 0; mstarted[i] = 0; mn[i] = 0; mseq[i] = 8'd0;
        end
    end

    // Reference model, advanced on every rising edge from the bench-driven inputs
    initial forever begin
        bit trig;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                mout[i] = 0; mbeat[i] = 0; mstarted[i] = 0; mseq[i] = 8'd0; mn[i] = 0;
                exp_q[i].delete();
            end else begin
                trig = req[i] || (i == 2 && (mn[i] % 64) == 63);
                mn[i]++;
                if (mout[i] > 0 && rdy[i]) begin
                    if (mbeat[i] == (16 >> i) - 1) begin
                        mbeat[i] = 0;
                        mout[i]--;
                        if (mout[i] > 0) start_rec(i);
                    end else begin
                        mbeat[i]++;
                    end
                end
                if (trig) begin
                    if (mout[i] == 0) begin
                        mout[i] = 1;
                        start_rec(i);
                    end else if (mout[i] == 1) begin
                        mout[i] = 2;
                    end
                end
            end
        end
    end

    // Monitor: compares outputs mid-cycle and retires beats on handshakes
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst[i]) begin
                chk("m_valid", i, 33'(vld[i]), 33'(mout[i] > 0));
                chk("busy", i, 33'(bsy[i]), 33'(mout[i] > 0));
                chk("seq", i, 33'(seqo[i]), 33'(mseq[i]));
                if (vld[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_beat inst%0d: got data %h, no beat expected", i, dd[i]);
                    end else begin
                        chk("beat", i, {lst[i], dd[i]}, exp_q[i][0]);
                        if (rdy[i]) void'(exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    // Ready drivers
    initial begin
        for (int i = 0; i < 3; i++) begin
            rdy[i] = 1'b0;
            rdy_mode[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                case (rdy_mode[i])
                    0:       rdy[i] = 1'b1;
                    1:       rdy[i] = 1'($urandom % 2);
                    default: rdy[i] = ($urandom % 10) < 7;
                endcase
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int i);
        req[i] = 1'b1;
        cyc(1);
        req[i] = 1'b0;
    endtask

    task automatic seq_w8();
        int t;
        rdy_mode[0] = 0;
        pulse(0);
        cyc(25);
        pulse(0);
        t = 0;
        while (!(mout[0] > 0 && mbeat[0] == 5) && t < 100) begin
            cyc(1);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat5_timeout inst0: got no beat 5 within %0d cycles", t);
        end
        rst[0] = 1'b1;
        #1;
        chk("rst_valid", 0, 33'(vld[0]), 33'd0);
        chk("rst_last", 0, 33'(lst[0]), 33'd0);
        chk("rst_data", 0, 33'(dd[0]), 33'd0);
        chk("rst_busy", 0, 33'(bsy[0]), 33'd0);
        chk("rst_seq", 0, 33'(seqo[0]), 33'd0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        cyc(10);
        pulse(0);
        cyc(20);
        rdy_mode[0] = 2;
        for (int k = 0; k < 400; k++) begin
            req[0] = ($urandom % 16) == 0;
            cyc(1);
        end
        req[0] = 1'b0;
    endtask

    task automatic seq_w16();
        rdy_mode[1] = 1;
        pulse(1);
        cyc(1);
        pulse(1);
        cyc(1);
        pulse(1);
        cyc(1);
        pulse(1);
        cyc(60);
        for (int k = 0; k < 400; k++) begin
            req[1] = ($urandom % 8) == 0;
            cyc(1);
        end
        req[1] = 1'b0;
    endtask

    task automatic seq_w32();
        int t;
        rdy_mode[2] = 1;
        t = 0;
        while (mstarted[2] < 258 && t < 20000) begin
            cyc(1);
            t++;
        end
        if (t >= 20000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL period_timeout inst2: got %0d records, required 258", mstarted[2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            req[i] = 1'b0;
        end
        #2;
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid", i, 33'(vld[i]), 33'd0);
            chk("reset_last", i, 33'(lst[i]), 33'd0);
            chk("reset_data", i, 33'(dd[i]), 33'd0);
            chk("reset_busy", i, 33'(bsy[i]), 33'd0);
            chk("reset_seq", i, 33'(seqo[i]), 33'd0);
        end
        cyc(3);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        fork
            seq_w8();
            seq_w16();
            seq_w32();
        join
        for (int i = 0; i < 3; i++) rdy_mode[i] = 0;
        cyc(40);
        chk("drained", 0, 33'(exp_q[0].size()), 33'd0);
        chk("drained", 1, 33'(exp_q[1].size()), 33'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/version_stream_tx.md
Name: version_stream_tx

Overview:
- Serialises the build-identification record (version and build timestamp constants from version_pkg) onto a valid/ready stream of configurable width.
- Feeds the host-visible debug/telemetry path, so software can fetch the firmware identity on demand or periodically.
- Adds packet framing, a magic header, a record sequence number and a checksum.
- Records are sent on a request pulse or from an internal periodic timer.

Parameters:
- DATA_W, 8: stream width in bits; legal values 8, 16, 32. Any other value is an elaboration error.
- MAGIC, 16'h5652: 2-byte header. Byte 0 is MAGIC[7:0], byte 1 is MAGIC[15:8].
- USER_ID, 8'h00: per-instance identifier byte placed in the record.
- PERIOD_CYCLES, 0: auto-emit interval in clk cycles. 0 disables the timer. Nonzero values must be >= 32.

Ports:
- clk  in  1  single clock domain
- rst  in  1  reset, asynchronous, active-high
- req  in  1  level-sampled each cycle; a high sample requests one record
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_last  out  1  high on the final beat of a record
- busy  out  1  high while a record is in flight or pending
- seq  out  8  sequence number of the most recently started record

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_last=0, m_data=0, busy=0, seq=0, pending=0, timer=0, state=IDLE. Reset mid-record abandons the record immediately; no beat is emitted after release until a new trigger.
- Record is 16 bytes, indexed B0..B15:
  - B0,B1 = MAGIC
  - B2 = MAJOR, B3 = MINOR, B4 = PATCH, B5 = BUILD
  - B6 = YEAR[15:8], B7 = YEAR[7:0]
  - B8 = MONTH, B9 = DAY, B10 = HOUR, B11 = MINUTE, B12 = SECOND
  - B13 = USER_ID
  - B14 = record sequence number
  - B15 = checksum, chosen so that (B0+...+B15) mod 256 = 0
- Beat packing:
  - BPB = DATA_W/8 bytes per beat; NBEATS = 16/BPB (16, 8 or 4).
  - Beat k carries bytes B(k*BPB) .. B(k*BPB+BPB-1), with the lowest-index byte in m_data[7:0] (little-endian).
  - m_last is asserted only on beat NBEATS-1.
- Checksum: the constant-byte sum is computed at elaboration time. B15 = -(CONST_SUM + B14) mod 256, an 8-bit wrap.
- Trigger: trig = req | timer_tick.
  - When PERIOD_CYCLES>0, timer counts 0..PERIOD_CYCLES-1 continuously. timer_tick is high when timer = PERIOD_CYCLES-1.
- FSM, states IDLE and SEND:
  - IDLE, trig sampled at edge k:
    - state goes to SEND; beat index = 0.
    - Record number latched: B14 = seq_next, where seq_next starts at 0 after reset and wraps 255->0.
    - seq output takes the latched value.
    - m_valid=1 from cycle k+1. Latency is one cycle.
  - SEND, on each handshake (m_valid & m_ready): beat index increments.
  - SEND, handshake on last beat:
    - pending=1: clear pending, start the next record with no bubble. m_valid stays high, and beat 0 of the new record (new seq) is presented the next cycle.
    - pending=0: go to IDLE with m_valid=0.
  - trig while SEND sets pending. Further triggers while pending=1 are collapsed (dropped). trig in the same cycle as the last-beat handshake also sets or uses pending, so it is never lost.
- Stream rules:
  - m_data and m_last are stable while m_valid & !m_ready.
  - m_valid never deasserts mid-record.
  - m_ready may be held low indefinitely with no data loss.
- busy = (state==SEND) | pending.

Test Plan:
- DATA_W=8, PERIOD_CYCLES=0, req pulse one cycle, m_ready=1:
  - 16 beats on consecutive cycles starting 1 cycle after the req sample.
  - B0=8'h52, B1=8'h56, B2..B12 match version_pkg constants, B13=8'h00, B14=8'h00.
  - Sum of all bytes mod 256 = 0; m_last only on beat 15.
- DATA_W=32, two req pulses with m_ready=1: 4 beats per record; first beat of record 0 = {B3,B2,8'h56,8'h52}; second record has B14=8'h01 with a checksum that differs by exactly -1 mod 256.
- DATA_W=16, random m_ready (50% duty), 3 req pulses issued during the first record:
  - Exactly 2 records (the extra triggers collapse into one pending).
  - Data held stable while stalled; no bubble between the two records.
- PERIOD_CYCLES=64, req tied low: a record starts every 64 cycles; seq increments 0,1,2...; wrap 255->0 is checked after 256 records.
- Assert rst at beat 5 of a record: outputs go to 0 asynchronously the same cycle; after release, m_valid stays 0 until req; the next record has B14=8'h00.
